// File: rtl/hamming_pkg.sv
// SECDED(39,32) constants plus encode / data-extract helpers shared by the instruction memory.
package hamming_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 39;
    localparam int unsigned SYN_W  = 6;
    localparam int unsigned POS_MAX = CODE_W - 1;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h00000013;

    // Positions 1..POS_MAX that are not powers of two carry data bits, LSB first.
    function automatic logic is_data_pos(input int p);
        return (p & (p - 1)) != 0;
    endfunction

    function automatic logic [CODE_W-1:0] secded_enc32(input logic [DATA_W-1:0] data);
        logic [CODE_W-1:0] cw;
        int di;
        cw = '0;
        di = 0;
        for (int p = 1; p < int'(CODE_W); p++) begin
            if (is_data_pos(p)) begin
                cw[p] = data[di];
                di++;
            end
        end
        for (int k = 0; k < int'(SYN_W); k++) begin
            for (int p = 1; p < int'(CODE_W); p++) begin
                if (is_data_pos(p) && p[k]) cw[1 << k] = cw[1 << k] ^ cw[p];
            end
        end
        cw[0] = ^cw[CODE_W-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] secded_data32(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] data;
        int di;
        data = '0;
        di = 0;
        for (int p = 1; p < int'(CODE_W); p++) begin
            if (is_data_pos(p)) begin
                data[di] = cw[p];
                di++;
            end
        end
        return data;
    endfunction
endpackage

// File: rtl/hamming_imem_dec.sv
// Combinational SECDED(39,32) decoder: corrects single flips, flags double flips with a NOP.
module secded_dec32
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data_c,
    output logic              sbe_c,
    output logic              dbe_c
);
    logic [SYN_W-1:0]  syn;
    logic              par;
    logic [CODE_W-1:0] fixed;

    always_comb begin
        syn = '0;
        for (int k = 0; k < int'(SYN_W); k++) begin
            for (int p = 1; p < int'(CODE_W); p++) begin
                if (p[k]) syn[k] = syn[k] ^ code[p];
            end
        end
    end

    assign par = ^code;

    // Odd parity: one flip at position syn (0 = parity bit); a syndrome past the word is uncorrectable.
    always_comb begin
        fixed = code;
        sbe_c = 1'b0;
        dbe_c = 1'b0;
        if (par) begin
            if (syn <= SYN_W'(POS_MAX)) begin
                fixed = code ^ (CODE_W'(1) << syn);
                sbe_c = 1'b1;
            end else begin
                dbe_c = 1'b1;
            end
        end else if (syn != '0) begin
            dbe_c = 1'b1;
        end
        data_c = dbe_c ? NOP_INSTR : secded_data32(fixed);
    end
endmodule

// File: rtl/hamming_imem.sv
// SECDED-protected instruction memory with a 2-stage fetch pipe and saturating error counters.
// Optional write-side error injection ports when HAMMING_ERR_INJECT_EN is defined.
module hamming_imem
    import hamming_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_we,
    input  logic [31:0]      imem_addr,
    input  logic [31:0]      imem_wdata,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [1:0]       inj_mode,
    input  logic [5:0]       inj_bit,
`endif
    output logic             fetch_valid,
    output logic [31:0]      fetch_data,
    output logic             fetch_sbe,
    output logic             fetch_dbe,
    output logic             err_fatal,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  word_vld;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              wr_ok;
    logic              rd_ok;
    logic [CODE_W-1:0] inj_mask;
    logic              s1_valid;
    logic              s1_hit;
    logic [CODE_W-1:0] s1_code;
    logic [DATA_W-1:0] dec_data;
    logic              dec_sbe;
    logic              dec_dbe;
    logic              hit_sbe;
    logic              hit_dbe;

    assign wr_idx = imem_addr[AW+1:2];
    assign rd_idx = fetch_addr[AW+1:2];
    assign wr_ok  = imem_we && ((imem_addr >> (AW + 2)) == 32'd0);
    assign rd_ok  = (fetch_addr >> (AW + 2)) == 32'd0;

`ifdef HAMMING_ERR_INJECT_EN
    logic [5:0] inj_next;
    assign inj_next = (inj_bit == 6'(POS_MAX)) ? 6'd0 : inj_bit + 6'd1;

    always_comb begin
        inj_mask = '0;
        if (inj_bit <= 6'(POS_MAX)) begin
            case (inj_mode)
                2'b01:   inj_mask = CODE_W'(1) << inj_bit;
                2'b10:   inj_mask = (CODE_W'(1) << inj_bit) | (CODE_W'(1) << inj_next);
                default: inj_mask = '0;
            endcase
        end
    end
`else
    assign inj_mask = '0;
`endif

    // Read-first array: the registered read sees the word present before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= secded_enc32(imem_wdata) ^ inj_mask;
        s1_code <= mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_vld <= '0;
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
        end else begin
            if (wr_ok) word_vld[wr_idx] <= 1'b1;
            s1_valid <= fetch_req;
            s1_hit   <= fetch_req && rd_ok && word_vld[rd_idx];
        end
    end

    secded_dec32 u_dec (
        .code   (s1_code),
        .data_c (dec_data),
        .sbe_c  (dec_sbe),
        .dbe_c  (dec_dbe)
    );

    assign hit_sbe = s1_hit && dec_sbe;
    assign hit_dbe = s1_hit && dec_dbe;

    // Misses (unwritten or out of range) return a NOP and never touch the statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            fetch_sbe   <= 1'b0;
            fetch_dbe   <= 1'b0;
            err_fatal   <= 1'b0;
            corr_cnt    <= '0;
            uncorr_cnt  <= '0;
        end else begin
            fetch_valid <= s1_valid;
            fetch_sbe   <= hit_sbe;
            fetch_dbe   <= hit_dbe;
            if (s1_valid) fetch_data <= s1_hit ? dec_data : NOP_INSTR;
            if (hit_sbe && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
            if (hit_dbe && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            if (hit_dbe) err_fatal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hamming_imem.sv
// Bench for hamming_imem: decoder vector table, directed fetch sequences and a random fetch burst.
module tb_hamming_imem;
    import hamming_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] data;
        logic        sbe;
        logic        dbe;
    } fexp_t;

    typedef struct {
        logic [31:0] data;
        int          nflip;
        int          p1;
        int          p2;
        logic [31:0] exp_data;
        logic        exp_sbe;
        logic        exp_dbe;
    } dvec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_sbe;
    logic        fetch_dbe;
    logic        err_fatal;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
`ifdef HAMMING_ERR_INJECT_EN
    logic [1:0]  inj_mode;
    logic [5:0]  inj_bit;
`endif

    logic [38:0] dcode;
    logic [31:0] d_data;
    logic        d_sbe;
    logic        d_dbe;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model: stored word, written flag and error kind (0 none, 1 single, 2 double).
    logic [31:0] m_data [64];
    bit          m_vld  [64];
    int          m_err  [64];
    logic [15:0] m_corr;
    logic [15:0] m_uncorr;
    bit          m_fatal;

    dvec_t       dtab [$];
    fexp_t       bexp [$];
    logic [38:0] cw;
    logic [5:0]  hsum;
    logic [31:0] dbits;
    fexp_t       e;

    always #5 clk = ~clk;

    hamming_imem dut (
        .clk        (clk),
        .rst        (rst),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_mode   (inj_mode),
        .inj_bit    (inj_bit),
`endif
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_sbe  (fetch_sbe),
        .fetch_dbe  (fetch_dbe),
        .err_fatal  (err_fatal),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    secded_dec32 u_dec_chk (
        .code   (dcode),
        .data_c (d_data),
        .sbe_c  (d_sbe),
        .dbe_c  (d_dbe)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic dvec_t mk_dvec(input logic [31:0] d, input int n, input int p1, input int p2);
        dvec_t v;
        v.data = d; v.nflip = n; v.p1 = p1; v.p2 = p2;
        v.exp_data = (n == 2) ? NOP : d;
        v.exp_sbe  = (n == 1);
        v.exp_dbe  = (n == 2);
        return v;
    endfunction

    function automatic fexp_t model_fetch(input logic [31:0] a);
        fexp_t r;
        int idx;
        r.data = NOP; r.sbe = 1'b0; r.dbe = 1'b0;
        idx = int'(a[7:2]);
        if (a[31:8] == 24'd0 && m_vld[idx]) begin
            if (m_err[idx] == 2) r.dbe = 1'b1;
            else begin
                r.data = m_data[idx];
                r.sbe  = (m_err[idx] == 1);
            end
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int kind);
        if (a[31:8] == 24'd0) begin
            m_data[int'(a[7:2])] = d;
            m_vld[int'(a[7:2])]  = 1'b1;
            m_err[int'(a[7:2])]  = kind;
        end
    endtask

    task automatic model_count(input fexp_t x);
        if (x.sbe && m_corr != 16'hFFFF) m_corr++;
        if (x.dbe && m_uncorr != 16'hFFFF) m_uncorr++;
        if (x.dbe) m_fatal = 1'b1;
    endtask

    task automatic chk_out(input string name, input fexp_t x);
        chk({name, "_valid"}, 64'(fetch_valid), 64'd1);
        chk({name, "_data"}, 64'(fetch_data), 64'(x.data));
        chk({name, "_sbe"}, 64'(fetch_sbe), 64'(x.sbe));
        chk({name, "_dbe"}, 64'(fetch_dbe), 64'(x.dbe));
        model_count(x);
    endtask

    task automatic chk_stats(input string name);
        chk({name, "_corr_cnt"}, 64'(corr_cnt), 64'(m_corr));
        chk({name, "_uncorr_cnt"}, 64'(uncorr_cnt), 64'(m_uncorr));
        chk({name, "_err_fatal"}, 64'(err_fatal), 64'(m_fatal));
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        imem_we = 1'b1; imem_addr = a; imem_wdata = d;
        step();
        imem_we = 1'b0;
        model_write(a, d, 0);
    endtask

`ifdef HAMMING_ERR_INJECT_EN
    task automatic write_inj(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] mode, input logic [5:0] b);
        int kind;
        kind = 0;
        if (b <= 6'd38 && mode == 2'b01) kind = 1;
        if (b <= 6'd38 && mode == 2'b10) kind = 2;
        imem_we = 1'b1; imem_addr = a; imem_wdata = d; inj_mode = mode; inj_bit = b;
        step();
        imem_we = 1'b0; inj_mode = 2'b00; inj_bit = 6'd0;
        model_write(a, d, kind);
    endtask
`endif

    // Isolated fetch: nothing at +1, one valid result at +2, idle again at +3.
    task automatic fetch_check(input string name, input logic [31:0] a);
        fexp_t x;
        x = model_fetch(a);
        fetch_req = 1'b1; fetch_addr = a;
        step();
        fetch_req = 1'b0;
        chk({name, "_lat1"}, 64'(fetch_valid), 64'd0);
        step();
        chk_out(name, x);
        step();
        chk({name, "_once"}, 64'(fetch_valid), 64'd0);
        chk_stats(name);
    endtask

    initial begin
        rst = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        fetch_req = 1'b0; fetch_addr = '0; dcode = '0;
`ifdef HAMMING_ERR_INJECT_EN
        inj_mode = 2'b00; inj_bit = 6'd0;
`endif
        for (int i = 0; i < 64; i++) begin m_vld[i] = 1'b0; m_err[i] = 0; m_data[i] = '0; end
        m_corr = '0; m_uncorr = '0; m_fatal = 1'b0;

        // Decoder vector table: clean, single and double flips at chosen and random positions.
        dtab.push_back(mk_dvec(32'h00500493, 0, 0, 0));
        dtab.push_back(mk_dvec(32'h00A00513, 1, 7, 0));
        dtab.push_back(mk_dvec(32'hFFFFFFFF, 1, 0, 0));
        dtab.push_back(mk_dvec(32'h12345678, 1, 38, 0));
        dtab.push_back(mk_dvec(32'h00000000, 1, 32, 0));
        dtab.push_back(mk_dvec(32'h0000006F, 2, 3, 4));
        dtab.push_back(mk_dvec(32'hDEADBEEF, 2, 38, 0));
        dtab.push_back(mk_dvec(32'hCAFEF00D, 2, 1, 2));
        for (int i = 0; i < 24; i++) begin
            int p1;
            p1 = int'($urandom_range(0, 38));
            dtab.push_back(mk_dvec($urandom, int'($urandom_range(0, 2)), p1,
                                   (p1 + int'($urandom_range(1, 38))) % 39));
        end
        foreach (dtab[i]) begin
            cw = secded_enc32(dtab[i].data);
            hsum = '0;
            dbits = '0;
            for (int p = 1, k = 0; p < 39; p++) begin
                if (cw[p]) hsum = hsum ^ 6'(p);
                if ((p & (p - 1)) != 0) begin dbits[k] = cw[p]; k++; end
            end
            chk($sformatf("enc%0d_syndrome", i), 64'(hsum), 64'd0);
            chk($sformatf("enc%0d_parity", i), 64'(^cw), 64'd0);
            chk($sformatf("enc%0d_layout", i), 64'(dbits), 64'(dtab[i].data));
            if (dtab[i].nflip >= 1) cw[dtab[i].p1] = ~cw[dtab[i].p1];
            if (dtab[i].nflip == 2) cw[dtab[i].p2] = ~cw[dtab[i].p2];
            dcode = cw;
            #1;
            chk($sformatf("dec%0d_data", i), 64'(d_data), 64'(dtab[i].exp_data));
            chk($sformatf("dec%0d_sbe", i), 64'(d_sbe), 64'(dtab[i].exp_sbe));
            chk($sformatf("dec%0d_dbe", i), 64'(d_dbe), 64'(dtab[i].exp_dbe));
        end

        step(); step();
        chk("rst_valid", 64'(fetch_valid), 64'd0);
        chk("rst_data", 64'(fetch_data), 64'd0);
        chk("rst_sbe", 64'(fetch_sbe), 64'd0);
        chk("rst_dbe", 64'(fetch_dbe), 64'd0);
        chk_stats("rst");
        rst = 1'b0;
        step();

        write_word(32'h0, 32'h00500493);
        fetch_check("addi", 32'h0);
        fetch_check("unwritten", 32'hC);
        fetch_check("out_of_range", 32'h400);
        write_word(32'h400, 32'hDEADBEEF);
        fetch_check("oor_write_dropped", 32'h0);

        // Same-cycle write and fetch to one index returns the previous word.
        e = model_fetch(32'h0);
        imem_we = 1'b1; imem_addr = 32'h0; imem_wdata = 32'h0000006F;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step();
        imem_we = 1'b0; fetch_req = 1'b0;
        model_write(32'h0, 32'h0000006F, 0);
        step();
        chk_out("read_first_old", e);
        step();
        fetch_check("read_first_new", 32'h0);

        // Random back-to-back burst against the model.
        for (int i = 0; i < 24; i++) write_word(32'(i * 8 + 4), $urandom);
        for (int i = 0; i < 42; i++) begin
            logic [31:0] a;
            if (i >= 2) chk_out($sformatf("burst%0d", i - 2), bexp[i - 2]);
            if (i < 40) begin
                case ($urandom_range(0, 9))
                    7, 8:    a = $urandom | 32'h00000100;
                    9:       a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                    default: a = {24'd0, 6'(($urandom_range(0, 23) * 2) + 1), 2'($urandom)};
                endcase
                bexp.push_back(model_fetch(a));
                fetch_req = 1'b1; fetch_addr = a;
            end else begin
                fetch_req = 1'b0;
            end
            step();
        end
        chk("burst_idle", 64'(fetch_valid), 64'd0);
        chk_stats("burst");

`ifdef HAMMING_ERR_INJECT_EN
        write_inj(32'h4, 32'h00A00513, 2'b01, 6'd7);
        fetch_check("inj_single", 32'h4);
        write_inj(32'h8, 32'h00100093, 2'b10, 6'd3);
        fetch_check("inj_double", 32'h8);
        write_inj(32'h14, 32'h00200113, 2'b10, 6'd38);
        fetch_check("inj_double_wrap", 32'h14);
        write_inj(32'h18, 32'h00300193, 2'b01, 6'd45);
        fetch_check("inj_bit_range", 32'h18);
        write_inj(32'h1C, 32'h00400213, 2'b11, 6'd5);
        fetch_check("inj_mode11", 32'h1C);
        write_inj(32'h10, 32'h00008067, 2'b01, 6'd0);
        fetch_check("inj_parity_bit", 32'h10);
        fetch_req = 1'b1; fetch_addr = 32'h10;
        for (int i = 0; i < 65540; i++) begin
            model_count(model_fetch(32'h10));
            step();
        end
        fetch_req = 1'b0;
        step(); step(); step();
        chk("sat_corr_cnt", 64'(corr_cnt), 64'(m_corr));
        chk("sat_corr_max", 64'(corr_cnt), 64'hFFFF);
        fetch_check("sat_hold", 32'h10);
`endif

        // Reset while a fetch is in flight: no result emerges and all state clears.
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step();
        fetch_req = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_valid", 64'(fetch_valid), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
        m_corr = '0; m_uncorr = '0; m_fatal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("postrst%0d_valid", i), 64'(fetch_valid), 64'd0);
            step();
        end
        chk_stats("postrst");
        fetch_check("postrst_cleared", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
